// File: rtl/scaler_v_sched.sv
// scaler_v_sched: line scheduler for the vertical linear scaler.
// Counts the input lines held in the line-buffer ring and steps a fixed-point
// output-line coordinate. When both source lines of the next output line are
// resident, it issues one generate request with the phase and the two ring
// slots. It also drives writer back-pressure, frame completion and overrun.
module scaler_v_sched #(
  parameter int LINE_STEP = 4096,
  parameter int BUF_COUNT = 3,
  parameter int DY_WIDTH  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         scale_step,
  input  logic [15:0]         line_in_count,
  input  logic [15:0]         line_out_count,
  input  logic                sof_i,
  input  logic                eol_i,
  output logic                in_ready,
  output logic                gen_start,
  output logic [DY_WIDTH-1:0] gen_dy,
  output logic [1:0]          gen_buf0,
  output logic [1:0]          gen_buf1,
  output logic                gen_first,
  output logic                gen_last,
  input  logic                gen_done,
  output logic                gen_abort,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  localparam int FRAC  = $clog2(LINE_STEP);
  localparam int ADV_W = 17 - FRAC + 16;
  localparam logic [1:0] KMOD_MAX = 2'(BUF_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_ISSUE   = 3'd2,
    S_BUSY    = 3'd3,
    S_ADVANCE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t              state_r;
  logic [15:0]         step_r;
  logic [15:0]         lin_cnt_r;
  logic [15:0]         lout_cnt_r;
  logic [15:0]         lines_done_r;
  logic [15:0]         k_r;
  logic [1:0]          kmod_r;
  logic [FRAC-1:0]     frac_r;
  logic [15:0]         out_cnt_r;
  logic [ADV_W-1:0]    adv_rem_r;

  logic                in_ready_r;
  logic                gen_start_r;
  logic [DY_WIDTH-1:0] gen_dy_r;
  logic [1:0]          gen_buf0_r;
  logic [1:0]          gen_buf1_r;
  logic                gen_first_r;
  logic                gen_last_r;
  logic                gen_abort_r;
  logic                busy_r;
  logic                frame_done_r;
  logic                overrun_r;

  logic [16:0]         k_plus1_s;
  logic [16:0]         lin_m1_s;
  logic [16:0]         k1_s;
  logic [16:0]         need_s;
  logic                k_last_s;
  logic [1:0]          kmod_inc_s;
  logic [1:0]          buf1_s;
  logic [16:0]         sum_s;
  logic                eol_acc_s;
  logic                k_inc_s;
  logic [15:0]         ld_nxt_s;
  logic [15:0]         k_nxt_s;
  logic                ready_nxt_s;

  // Source-line selection, ring indices, phase sum and next-cycle occupancy.
  always_comb begin
    k_plus1_s = {1'b0, k_r} + 17'd1;
    lin_m1_s  = {1'b0, lin_cnt_r} - 17'd1;
    if (k_plus1_s < lin_m1_s) begin
      k1_s = k_plus1_s;
    end else begin
      k1_s = lin_m1_s;
    end
    need_s   = k1_s + 17'd1;
    k_last_s = ({1'b0, k_r} == lin_m1_s);
    if (kmod_r == KMOD_MAX) begin
      kmod_inc_s = 2'd0;
    end else begin
      kmod_inc_s = kmod_r + 2'd1;
    end
    // At the bottom edge both taps read the same (last) line.
    if (k1_s == {1'b0, k_r}) begin
      buf1_s = kmod_r;
    end else begin
      buf1_s = kmod_inc_s;
    end
    sum_s     = {{(17-FRAC){1'b0}}, frac_r} + {1'b0, step_r};
    eol_acc_s = eol_i & ~sof_i & (lines_done_r < lin_cnt_r);
    k_inc_s   = ~sof_i & (state_r == S_ADVANCE) &
                (adv_rem_r != {ADV_W{1'b0}}) & ~k_last_s;
    if (sof_i) begin
      ld_nxt_s = 16'd0;
      k_nxt_s  = 16'd0;
    end else begin
      ld_nxt_s = lines_done_r + {15'd0, eol_acc_s};
      k_nxt_s  = k_r + {15'd0, k_inc_s};
    end
    // The writer may run up to BUF_COUNT lines ahead of the top source line.
    ready_nxt_s = ({1'b0, ld_nxt_s} < ({1'b0, k_nxt_s} + 17'(BUF_COUNT)));
  end

  // Scheduler FSM together with all counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      step_r       <= 16'd0;
      lin_cnt_r    <= 16'd0;
      lout_cnt_r   <= 16'd0;
      lines_done_r <= 16'd0;
      k_r          <= 16'd0;
      kmod_r       <= 2'd0;
      frac_r       <= {FRAC{1'b0}};
      out_cnt_r    <= 16'd0;
      adv_rem_r    <= {ADV_W{1'b0}};
      in_ready_r   <= 1'b1;
      gen_start_r  <= 1'b0;
      gen_dy_r     <= {DY_WIDTH{1'b0}};
      gen_buf0_r   <= 2'd0;
      gen_buf1_r   <= 2'd0;
      gen_first_r  <= 1'b0;
      gen_last_r   <= 1'b0;
      gen_abort_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      gen_start_r  <= 1'b0;
      gen_abort_r  <= 1'b0;
      frame_done_r <= 1'b0;
      in_ready_r   <= ready_nxt_s;
      lines_done_r <= ld_nxt_s;
      k_r          <= k_nxt_s;
      if (sof_i) begin
        step_r     <= scale_step;
        lin_cnt_r  <= line_in_count;
        lout_cnt_r <= line_out_count;
        kmod_r     <= 2'd0;
        frac_r     <= {FRAC{1'b0}};
        out_cnt_r  <= 16'd0;
        adv_rem_r  <= {ADV_W{1'b0}};
        overrun_r  <= 1'b0;
        busy_r     <= 1'b1;
        gen_abort_r <= (state_r == S_ISSUE) || (state_r == S_BUSY);
        if (line_out_count == 16'd0) begin
          state_r      <= S_DONE;
          frame_done_r <= 1'b1;
        end else begin
          state_r <= S_WAIT;
        end
      end else begin
        if (eol_i && !in_ready_r) begin
          overrun_r <= 1'b1;
        end
        case (state_r)
          S_IDLE: begin
            busy_r <= 1'b0;
          end
          S_WAIT: begin
            if ({1'b0, lines_done_r} >= need_s) begin
              state_r     <= S_ISSUE;
              gen_start_r <= 1'b1;
              gen_dy_r    <= frac_r[FRAC-1 -: DY_WIDTH];
              gen_buf0_r  <= kmod_r;
              gen_buf1_r  <= buf1_s;
              gen_first_r <= (out_cnt_r == 16'd0);
              gen_last_r  <= ({1'b0, out_cnt_r} == ({1'b0, lout_cnt_r} - 17'd1));
            end
          end
          S_ISSUE: begin
            state_r <= S_BUSY;
          end
          S_BUSY: begin
            if (gen_done) begin
              frac_r    <= sum_s[FRAC-1:0];
              adv_rem_r <= ADV_W'(sum_s >> FRAC);
              out_cnt_r <= out_cnt_r + 16'd1;
              state_r   <= S_ADVANCE;
            end
          end
          S_ADVANCE: begin
            if (adv_rem_r != {ADV_W{1'b0}}) begin
              adv_rem_r <= adv_rem_r - ADV_W'(1);
              if (k_inc_s) begin
                kmod_r <= kmod_inc_s;
              end
            end else if (out_cnt_r == lout_cnt_r) begin
              state_r      <= S_DONE;
              frame_done_r <= 1'b1;
            end else begin
              state_r <= S_WAIT;
            end
          end
          S_DONE: begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign gen_start  = gen_start_r;
  assign gen_dy     = gen_dy_r;
  assign gen_buf0   = gen_buf0_r;
  assign gen_buf1   = gen_buf1_r;
  assign gen_first  = gen_first_r;
  assign gen_last   = gen_last_r;
  assign gen_abort  = gen_abort_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

endmodule
